spi_share: RTL

Shares one SPI shift engine among the three SPI requesters of the NeoGS FPGA port block: SD card, MP3 control and MP3 data. Each requester issues single-cycle start strobes with a data byte. The block buffers pending requests and arbitrates by fixed priority. It runs one mode-0 byte transfer at a per-requester SCLK rate, then returns the received byte and a ready flag to the Z80-visible registers. It sits between the port decoder and the board SPI pins; the port decoder keeps ownership of the chip selects.

---
 rtl/spi_share_pkg.sv | 27 ++
 rtl/spi_share_slot.sv | 91 +++++++++
 rtl/spi_share.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spi_share_pkg.sv
// Shared definitions for the spi_share block: requester IDs, arbiter state
// encoding and the per-requester SCLK half-period helpers.
package spi_share_pkg;

  localparam logic [1:0] REQ_SD   = 2'd0;
  localparam logic [1:0] REQ_MC   = 2'd1;
  localparam logic [1:0] REQ_MD   = 2'd2;
  localparam logic [1:0] REQ_NONE = 2'd3;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // MP3 control runs at 1, 2, 4 or 8 cycles per SCLK half-period.
  function automatic logic [3:0] mc_half(input logic [1:0] speed);
    return 4'd1 << speed;
  endfunction

  function automatic logic [3:0] md_half(input logic halfspeed);
    return halfspeed ? 4'd2 : 4'd1;
  endfunction

endpackage

// File: rtl/spi_share_slot.sv
// One requester's request slot: a byte plus full/active flags. Defining
// SPI_SHARE_PENDQ_EN adds a second queued entry behind the head.
module spi_share_slot
  import spi_share_pkg::*;
(
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       grant,
  input  logic       done,
  output logic       pending,
  output logic [7:0] data,
  output logic       rdy
);

  logic       v0, act;
  logic [7:0] b0;
  logic       n_v0, n_act;
  logic [7:0] n_b0;
`ifdef SPI_SHARE_PENDQ_EN
  logic       v1, n_v1;
  logic [7:0] b1, n_b1;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    n_v0  = v0;
    n_b0  = b0;
    n_act = act;
`ifdef SPI_SHARE_PENDQ_EN
    n_v1  = v1;
    n_b1  = b1;
`endif
    if (grant) n_act = 1'b1;
    if (done) begin
      n_act = 1'b0;
`ifdef SPI_SHARE_PENDQ_EN
      n_v0 = v1;
      n_b0 = b1;
      n_v1 = 1'b0;
`else
      n_v0 = 1'b0;
`endif
    end
    // The free happens first, so a strobe on the done edge refills the slot.
    if (start) begin
      if (!n_v0) begin
        n_v0 = 1'b1;
        n_b0 = din;
      end
`ifdef SPI_SHARE_PENDQ_EN
      else if (!n_v1) begin
        n_v1 = 1'b1;
        n_b1 = din;
      end
`endif
    end
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    if (!rst_n) begin
      v0  <= 1'b0;
      b0  <= 8'h00;
      act <= 1'b0;
      rdy <= 1'b1;
`ifdef SPI_SHARE_PENDQ_EN
      v1  <= 1'b0;
      b1  <= 8'h00;
`endif
    end else begin
      v0  <= n_v0;
      b0  <= n_b0;
      act <= n_act;
`ifdef SPI_SHARE_PENDQ_EN
      v1  <= n_v1;
      b1  <= n_b1;
      rdy <= ~(n_v0 | n_v1);
`else
      rdy <= ~n_v0;
`endif
    end
  end

  assign pending = v0 & ~act;
  assign data    = b0;

endmodule

// File: rtl/spi_share.sv
// Fixed-priority (MD > MC > SD) sharing of one mode-0 SPI shift engine.
// Optional two-entry request queues per requester: define SPI_SHARE_PENDQ_EN.
module spi_share
  import spi_share_pkg::*;
#(
  parameter int SD_HALF = 1
) (
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       sd_start,
  input  logic       mc_start,
  input  logic       md_start,
  input  logic [7:0] sd_din,
  input  logic [7:0] mc_din,
  input  logic [7:0] md_din,
  input  logic       md_halfspeed,
  input  logic [1:0] mc_speed,
  output logic [7:0] sd_dout,
  output logic [7:0] mc_dout,
  output logic       sd_rdy,
  output logic       mc_rdy,
  output logic       md_rdy,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [1:0] spi_sel
);

  localparam logic [3:0] SD_HALF_W = 4'(SD_HALF);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] half_m1, cnt, bit_cnt;

  logic [NUM_REQ-1:0] grant, done, pending;
  logic [7:0] sd_data, mc_data, md_data;
  logic [1:0] gnt_id;
  logic [7:0] gnt_data;
  logic [3:0] gnt_half, gnt_half_m1;

  spi_share_slot u_sd (
    .cpu_clock, .rst_n, .start(sd_start), .din(sd_din),
    .grant(grant[REQ_SD]), .done(done[REQ_SD]),
    .pending(pending[REQ_SD]), .data(sd_data), .rdy(sd_rdy)
  );

  spi_share_slot u_mc (
    .cpu_clock, .rst_n, .start(mc_start), .din(mc_din),
    .grant(grant[REQ_MC]), .done(done[REQ_MC]),
    .pending(pending[REQ_MC]), .data(mc_data), .rdy(mc_rdy)
  );

  spi_share_slot u_md (
    .cpu_clock, .rst_n, .start(md_start), .din(md_din),
    .grant(grant[REQ_MD]), .done(done[REQ_MD]),
    .pending(pending[REQ_MD]), .data(md_data), .rdy(md_rdy)
  );

  // Grant only from IDLE; the half-period is frozen into half_m1 at grant.
  always_comb begin
    gnt_id   = REQ_NONE;
    gnt_data = 8'hFF;
    gnt_half = 4'd1;
    if (state == IDLE) begin
      if (pending[REQ_MD]) begin
        gnt_id   = REQ_MD;
        gnt_data = md_data;
        gnt_half = md_half(md_halfspeed);
      end else if (pending[REQ_MC]) begin
        gnt_id   = REQ_MC;
        gnt_data = mc_data;
        gnt_half = mc_half(mc_speed);
      end else if (pending[REQ_SD]) begin
        gnt_id   = REQ_SD;
        gnt_data = sd_data;
        gnt_half = SD_HALF_W;
      end
    end
  end

  assign gnt_half_m1 = gnt_half - 4'd1;
  assign grant = {gnt_id == REQ_MD, gnt_id == REQ_MC, gnt_id == REQ_SD};
  assign done  = (state == DONE) ? {spi_sel == REQ_MD, spi_sel == REQ_MC, spi_sel == REQ_SD}
                                 : 3'b000;

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      spi_sel  <= REQ_NONE;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b1;
      shreg    <= 8'h00;
      half_m1  <= 3'd0;
      cnt      <= 3'd0;
      bit_cnt  <= 3'd0;
      sd_dout  <= 8'hFF;
      mc_dout  <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_id != REQ_NONE) begin
            state    <= SHIFT;
            spi_sel  <= gnt_id;
            shreg    <= gnt_data;
            spi_mosi <= gnt_data[7];
            half_m1  <= gnt_half_m1[2:0];
            cnt      <= 3'd0;
            bit_cnt  <= 3'd0;
            spi_sck  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt == half_m1) begin
            cnt <= 3'd0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              // End of the high phase: capture miso, present the next bit.
              spi_sck <= 1'b0;
              shreg   <= {shreg[6:0], spi_miso};
              if (bit_cnt == 3'd7) begin
                state    <= DONE;
                spi_mosi <= 1'b1;
              end else begin
                spi_mosi <= shreg[6];
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (spi_sel == REQ_SD) sd_dout <= shreg;
          if (spi_sel == REQ_MC) mc_dout <= shreg;
          state   <= IDLE;
          spi_sel <= REQ_NONE;
        end
        default: begin
          state   <= IDLE;
          spi_sel <= REQ_NONE;
        end
      endcase
    end
  end

endmodule
